// File: rtl/psum_accumulator_pkg.sv
// ----------------------------------------------------------------------------
// psum_accumulator_pkg
//
// Purpose : Shared constants, state encoding and configuration decode for the
//           partial-sum accumulator and its row buffer.
//
// Contents:
//   NUM_ROWS / BEATS_PER_ROW / BUF_DEPTH  output-map geometry (61 x 31 = 1891)
//   LAST_ROW / LAST_BEAT                  terminal counter values
//   *_W                                   counter and address widths
//   state_t                               job FSM encoding
//   cfg_decode()                          3-bit count code -> 8/16/24/32
//   cfg_last_index()                      3-bit count code -> count-1
// ----------------------------------------------------------------------------
package psum_accumulator_pkg;

    // Output map is 61x61; two columns per beat gives 31 beats per row, the
    // last beat carrying a single column.
    localparam int NUM_ROWS      = 61;
    localparam int BEATS_PER_ROW = 31;
    localparam int BUF_DEPTH     = NUM_ROWS * BEATS_PER_ROW;
    localparam int LAST_ROW      = NUM_ROWS - 1;
    localparam int LAST_BEAT     = BEATS_PER_ROW - 1;

    localparam int BEAT_W = 5;   // 0..30
    localparam int ROW_W  = 6;   // 0..60
    localparam int CH_W   = 5;   // 0..31, also used for the kernel counter
    localparam int ADDR_W = 11;  // 0..1890

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Channel / kernel count encoding; unused codes fall back to 32.
    function automatic logic [5:0] cfg_decode(input logic [2:0] code);
        case (code)
            3'd0:    return 6'd8;
            3'd1:    return 6'd16;
            3'd2:    return 6'd24;
            default: return 6'd32;
        endcase
    endfunction

    // Terminal counter value for a given count code. The counters compare
    // against this instead of the count so they stay CH_W bits wide.
    function automatic logic [CH_W-1:0] cfg_last_index(input logic [2:0] code);
        logic [5:0] count;
        count = cfg_decode(code);
        return CH_W'(count - 6'd1);
    endfunction

endpackage

// File: rtl/psum_buffer.sv
// ----------------------------------------------------------------------------
// psum_buffer
//
// Purpose : Running-sum storage for one output map. One entry per
//           (row, beat) position, each entry holding both lanes packed as
//           {lane1, lane0}. Read is combinational so the accumulator can add
//           and write back in the same cycle; write is synchronous.
//
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address, row*31+beat
//   wr_data  in   {lane1, lane0} to store
//   rd_addr  in   read address, row*31+beat
//   rd_data  out  {lane1, lane0} currently stored at rd_addr
// ----------------------------------------------------------------------------
module psum_buffer
    import psum_accumulator_pkg::*;
#(
    parameter int WIDTH = 60
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    // No reset: channel 0 of every kernel overwrites each entry before it is
    // ever read back.
    logic [WIDTH-1:0] mem [BUF_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-before-write: a read and write to the same address in one cycle
    // returns the old contents, which is exactly the accumulate operand.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/psum_accumulator.sv
// ----------------------------------------------------------------------------
// psum_accumulator
//
// Purpose : Sums per-channel partial sums of a 61x61 convolution output map
//           across Nci input channels, for each of Nco kernels. Channel 0
//           seeds the buffer, middle channels accumulate into it, and the last
//           channel's sum is emitted directly without a write-back.
//
// Parameters:
//   LEN_IN   width of one signed per-channel partial sum
//   LEN_OUT  width of the channel-summed result (LEN_IN + 5 is exact for 32)
//
// Ports:
//   clk            in   clock, all state on rising edge
//   rst            in   asynchronous active-high reset
//   in_start_conv  in   start a job (honoured only in IDLE)
//   in_cfg_ci      in   channel count code, latched at start
//   in_cfg_co      in   kernel count code, latched at start
//   in_valid       in   one partial-sum beat present
//   in_psum0/1     in   partial sums for columns 2b and 2b+1
//   out_valid      out  result beat valid (registered)
//   out_data0/1    out  channel-summed results, zero when not valid
//   out_half       out  last beat of a row: only out_data0 meaningful
//   out_end_conv   out  one-cycle job-complete pulse
//
// Stream order: beat (0..30) within row (0..60) within channel within kernel.
// ----------------------------------------------------------------------------
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int LEN_IN  = 25,
    parameter int LEN_OUT = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_start_conv,
    input  logic [2:0]         in_cfg_ci,
    input  logic [2:0]         in_cfg_co,
    input  logic               in_valid,
    input  logic [LEN_IN-1:0]  in_psum0,
    input  logic [LEN_IN-1:0]  in_psum1,
    output logic               out_valid,
    output logic [LEN_OUT-1:0] out_data0,
    output logic [LEN_OUT-1:0] out_data1,
    output logic               out_half,
    output logic               out_end_conv
);

    localparam int EXT_W = LEN_OUT - LEN_IN;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_reg;
    logic [BEAT_W-1:0]  beat_reg;
    logic [ROW_W-1:0]   row_reg;
    logic [CH_W-1:0]    ch_reg;
    logic [CH_W-1:0]    kernel_reg;
    logic [CH_W-1:0]    ch_last_reg;
    logic [CH_W-1:0]    kernel_last_reg;

    logic               out_valid_reg;
    logic               out_half_reg;
    logic               out_end_conv_reg;
    logic [LEN_OUT-1:0] out_data_reg [2];

    // ------------------------------------------------------------------
    // Datapath signals
    // ------------------------------------------------------------------
    logic                 accept;
    logic                 last_beat;
    logic                 last_row;
    logic                 last_ch;
    logic                 last_kernel;
    logic                 first_ch;
    logic                 job_last;
    logic [ADDR_W-1:0]    buf_addr;
    logic                 buf_wr_en;
    logic [2*LEN_OUT-1:0] buf_rd;
    logic [2*LEN_OUT-1:0] buf_wr;

    logic [LEN_IN-1:0]    psum_in     [2];
    logic [LEN_OUT-1:0]   lane_ext    [2];
    logic [LEN_OUT-1:0]   lane_stored [2];
    logic [LEN_OUT-1:0]   lane_sum    [2];
    logic [LEN_OUT-1:0]   lane_out    [2];

    assign accept      = (state_reg == ST_ACCUM) && in_valid;
    assign last_beat   = (beat_reg == BEAT_W'(LAST_BEAT));
    assign last_row    = (row_reg == ROW_W'(LAST_ROW));
    assign last_ch     = (ch_reg == ch_last_reg);
    assign last_kernel = (kernel_reg == kernel_last_reg);
    assign first_ch    = (ch_reg == '0);
    assign job_last    = last_beat && last_row && last_ch && last_kernel;

    assign buf_addr = ADDR_W'(row_reg) * ADDR_W'(BEATS_PER_ROW) + ADDR_W'(beat_reg);

    // The last channel's sum goes straight to the output, so only channels
    // 0..Nci-2 touch the buffer.
    assign buf_wr_en = accept && !last_ch;

    assign psum_in[0] = in_psum0;
    assign psum_in[1] = in_psum1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        assign lane_ext[gi]    = {{EXT_W{psum_in[gi][LEN_IN-1]}}, psum_in[gi]};
        assign lane_stored[gi] = buf_rd[gi*LEN_OUT +: LEN_OUT];
        assign lane_sum[gi]    = lane_stored[gi] + lane_ext[gi];

        // Channel 0 seeds the entry; later channels accumulate onto it.
        assign buf_wr[gi*LEN_OUT +: LEN_OUT] = first_ch ? lane_ext[gi] : lane_sum[gi];

        // Lane 1 carries no column on the final beat of a row (column 61
        // does not exist), so its result is forced to zero there.
        if (gi == 0) begin : g_full
            assign lane_out[gi] = lane_sum[gi];
        end else begin : g_masked
            assign lane_out[gi] = last_beat ? '0 : lane_sum[gi];
        end
    end

    psum_buffer #(
        .WIDTH (2 * LEN_OUT)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (buf_wr_en),
        .wr_addr (buf_addr),
        .wr_data (buf_wr),
        .rd_addr (buf_addr),
        .rd_data (buf_rd)
    );

    // ------------------------------------------------------------------
    // FSM, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            beat_reg         <= '0;
            row_reg          <= '0;
            ch_reg           <= '0;
            kernel_reg       <= '0;
            ch_last_reg      <= '0;
            kernel_last_reg  <= '0;
            out_valid_reg    <= 1'b0;
            out_half_reg     <= 1'b0;
            out_end_conv_reg <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                out_data_reg[i] <= '0;
            end
        end else begin
            // Outputs are single-cycle pulses unless re-armed below.
            out_valid_reg    <= 1'b0;
            out_half_reg     <= 1'b0;
            out_end_conv_reg <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                out_data_reg[i] <= '0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (in_start_conv) begin
                        ch_last_reg     <= cfg_last_index(in_cfg_ci);
                        kernel_last_reg <= cfg_last_index(in_cfg_co);
                        beat_reg        <= '0;
                        row_reg         <= '0;
                        ch_reg          <= '0;
                        kernel_reg      <= '0;
                        state_reg       <= ST_ACCUM;
                    end
                end

                ST_ACCUM: begin
                    if (in_valid) begin
                        if (last_ch) begin
                            out_valid_reg <= 1'b1;
                            out_half_reg  <= last_beat;
                            for (int i = 0; i < 2; i++) begin
                                out_data_reg[i] <= lane_out[i];
                            end
                        end

                        // Nested rollover: beat -> row -> channel -> kernel.
                        // Kernel rollover lands on channel 0 immediately, so
                        // the next kernel streams with no idle cycle.
                        if (!last_beat) begin
                            beat_reg <= beat_reg + BEAT_W'(1);
                        end else begin
                            beat_reg <= '0;
                            if (!last_row) begin
                                row_reg <= row_reg + ROW_W'(1);
                            end else begin
                                row_reg <= '0;
                                if (!last_ch) begin
                                    ch_reg <= ch_reg + CH_W'(1);
                                end else begin
                                    ch_reg <= '0;
                                    if (!last_kernel) begin
                                        kernel_reg <= kernel_reg + CH_W'(1);
                                    end else begin
                                        kernel_reg <= '0;
                                    end
                                end
                            end
                        end

                        if (job_last) begin
                            state_reg <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    // The final result beat is on the outputs while in DONE;
                    // the completion pulse is launched here so it follows
                    // that beat by exactly one cycle.
                    out_end_conv_reg <= 1'b1;
                    state_reg        <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_half     = out_half_reg;
    assign out_data0    = out_data_reg[0];
    assign out_data1    = out_data_reg[1];
    assign out_end_conv = out_end_conv_reg;

endmodule

// File: tb/tb_psum_accumulator.sv
// ----------------------------------------------------------------------------
// tb_psum_accumulator
//
// Directed bench for psum_accumulator. A stream driver walks the
// kernel/channel/row/beat order, applies per-mode partial sums, and tallies
// every output cycle against the hand-computed result for that position.
// Scenario tasks then compare the tallies and spot values against constants.
// ----------------------------------------------------------------------------
module tb_psum_accumulator;

    localparam int LEN_IN  = 25;
    localparam int LEN_OUT = 30;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_start_conv;
    logic [2:0]         in_cfg_ci;
    logic [2:0]         in_cfg_co;
    logic               in_valid;
    logic [LEN_IN-1:0]  in_psum0;
    logic [LEN_IN-1:0]  in_psum1;
    logic               out_valid;
    logic [LEN_OUT-1:0] out_data0;
    logic [LEN_OUT-1:0] out_data1;
    logic               out_half;
    logic               out_end_conv;

    always #5 clk = ~clk;

    psum_accumulator #(
        .LEN_IN  (LEN_IN),
        .LEN_OUT (LEN_OUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_start_conv (in_start_conv),
        .in_cfg_ci     (in_cfg_ci),
        .in_cfg_co     (in_cfg_co),
        .in_valid      (in_valid),
        .in_psum0      (in_psum0),
        .in_psum1      (in_psum1),
        .out_valid     (out_valid),
        .out_data0     (out_data0),
        .out_data1     (out_data1),
        .out_half      (out_half),
        .out_end_conv  (out_end_conv)
    );

    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;

    // Per-stream tallies filled by observe().
    int    st_bad;
    int    st_valid;
    int    st_half;
    int    st_end;
    int    st_end_cyc;
    int    st_last_valid_cyc;
    string st_first_bad;

    // Apply inputs, advance one clock, and land 1 time unit past the edge.
    task automatic drive(input logic v, input logic [LEN_IN-1:0] p0,
                         input logic [LEN_IN-1:0] p1, input logic st);
        in_valid      = v;
        in_psum0      = p0;
        in_psum1      = p1;
        in_start_conv = st;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Tally one output cycle against the expected output tuple.
    task automatic observe(input logic ev, input logic eh,
                           input logic [LEN_OUT-1:0] e0, input logic [LEN_OUT-1:0] e1,
                           input logic ee);
        if (out_valid === 1'b1) begin
            st_valid++;
            st_last_valid_cyc = cyc;
            if (out_half === 1'b1) st_half++;
        end
        if (out_end_conv === 1'b1) begin
            st_end++;
            st_end_cyc = cyc;
        end
        if ({out_valid, out_half, out_data0, out_data1, out_end_conv} !== {ev, eh, e0, e1, ee}) begin
            if (st_bad == 0) begin
                st_first_bad = $sformatf(
                    "cyc %0d got v=%b h=%b d0=%0d d1=%0d e=%b want v=%b h=%b d0=%0d d1=%0d e=%b",
                    cyc, out_valid, out_half, $signed(out_data0), $signed(out_data1), out_end_conv,
                    ev, eh, $signed(e0), $signed(e1), ee);
            end
            st_bad++;
        end
    endtask

    // Stream one job. mode 0: both lanes 1. mode 2: lane0 = channel index,
    // lane1 = 100 on row 0 and -2^24 on later rows. e0/e1/e1b are the
    // expected sums (e1b applies to rows >= 1). A stop position >= 0 ends the
    // stream right after that beat's output is sampled.
    task automatic run_stream(input int nci, input logic [2:0] ci_code,
                              input int nco, input logic [2:0] co_code,
                              input int mode, input int gap_pct, input bit poke,
                              input int stop_k, input int stop_c, input int stop_r, input int stop_b,
                              input logic [LEN_OUT-1:0] e0, input logic [LEN_OUT-1:0] e1,
                              input logic [LEN_OUT-1:0] e1b);
        logic [LEN_IN-1:0]  p0;
        logic [LEN_IN-1:0]  p1;
        logic [LEN_OUT-1:0] exp1;
        st_bad = 0; st_valid = 0; st_half = 0; st_end = 0;
        st_end_cyc = -100; st_last_valid_cyc = 0; st_first_bad = "none";

        in_cfg_ci = ci_code;
        in_cfg_co = co_code;
        drive(1'b0, '0, '0, 1'b1);
        observe(1'b0, 1'b0, '0, '0, 1'b0);
        if (poke) begin
            // Live config now disagrees with the latched one.
            in_cfg_ci = 3'd3;
            in_cfg_co = 3'd3;
        end

        for (int k = 0; k < nco; k++) begin
            for (int c = 0; c < nci; c++) begin
                for (int r = 0; r < 61; r++) begin
                    for (int b = 0; b < 31; b++) begin
                        if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                            drive(1'b0, LEN_IN'($urandom), LEN_IN'($urandom), 1'b0);
                            observe(1'b0, 1'b0, '0, '0, 1'b0);
                        end
                        if (mode == 0) begin
                            p0 = LEN_IN'(1);
                            p1 = LEN_IN'(1);
                        end else begin
                            p0 = LEN_IN'(c);
                            p1 = (r == 0) ? LEN_IN'(100) : 25'h1000000;
                        end
                        if (b == 30) p1 = 25'h0ABCDE;  // must be ignored
                        drive(1'b1, p0, p1, poke && (b == 7));
                        if (c == nci - 1) begin
                            exp1 = (b == 30) ? '0 : ((r == 0) ? e1 : e1b);
                            observe(1'b1, b == 30, e0, exp1, 1'b0);
                        end else begin
                            observe(1'b0, 1'b0, '0, '0, 1'b0);
                        end
                        if (k == stop_k && c == stop_c && r == stop_r && b == stop_b) return;
                    end
                end
            end
        end

        // DONE cycle, then IDLE; in_valid is held high and must be ignored.
        drive(1'b1, 25'h0000123, 25'h0000456, 1'b0);
        observe(1'b0, 1'b0, '0, '0, 1'b1);
        drive(1'b1, 25'h0000123, 25'h0000456, 1'b0);
        observe(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        observe(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_start_conv = 1'b0; in_valid = 1'b0;
        in_cfg_ci = 3'd0; in_cfg_co = 3'd0; in_psum0 = '0; in_psum1 = '0;
        #3;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", out_valid); else n_pass++;
        n_checks++; if (out_half !== 1'b0) $display("FAIL reset_half: got %b required 0", out_half); else n_pass++;
        n_checks++; if (out_data0 !== '0) $display("FAIL reset_data0: got %0h required 0", out_data0); else n_pass++;
        n_checks++; if (out_data1 !== '0) $display("FAIL reset_data1: got %0h required 0", out_data1); else n_pass++;
        n_checks++; if (out_end_conv !== 1'b0) $display("FAIL reset_end: got %b required 0", out_end_conv); else n_pass++;
        // Activity while held in reset must not leak out.
        repeat (3) drive(1'b1, LEN_IN'(5), LEN_IN'(5), 1'b1);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_hold_valid: got %b required 0", out_valid); else n_pass++;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_start_conv = 1'b0;
        $display("test_reset: done");
    endtask

    task automatic test_idle_valid();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 25'h00ABCDE, 25'h0012345, 1'b0);
            n_checks++;
            if (out_valid !== 1'b0 || out_data0 !== '0)
                $display("FAIL idle_valid[%0d]: got v=%b d0=%0h required v=0 d0=0", i, out_valid, out_data0);
            else n_pass++;
        end
        drive(1'b0, '0, '0, 1'b0);
        $display("test_idle_valid: done");
    endtask

    // Nci=16, gapped; lane0 = c (sum 120), lane1 = 100 (sum 1600) on row 0
    // and -2^24 (sum -2^28 = 30'h3000_0000) on row 1. Stop at kernel 0,
    // last channel, row 1, beat 10 and reset asynchronously mid-cycle.
    task automatic test_lanes_gapped_reset();
        run_stream(16, 3'd1, 8, 3'd0, 2, 15, 1'b0, 0, 15, 1, 10,
                   30'd120, 30'd1600, 30'h3000_0000);
        n_checks++; if (st_bad !== 0) $display("FAIL lanes_data: %0d bad cycles required 0, first %s", st_bad, st_first_bad); else n_pass++;
        n_checks++; if (st_valid !== 42) $display("FAIL lanes_valid_count: got %0d required 42", st_valid); else n_pass++;
        n_checks++; if (st_half !== 1) $display("FAIL lanes_half_count: got %0d required 1", st_half); else n_pass++;
        n_checks++; if (st_end !== 0) $display("FAIL lanes_end_count: got %0d required 0", st_end); else n_pass++;
        n_checks++; if (out_valid !== 1'b1 || out_data0 !== 30'd120) $display("FAIL lanes_pre_reset: got v=%b d0=%0d required v=1 d0=120", out_valid, $signed(out_data0)); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL midjob_reset_valid: got %b required 0", out_valid); else n_pass++;
        n_checks++; if (out_data0 !== '0) $display("FAIL midjob_reset_data0: got %0h required 0", out_data0); else n_pass++;
        n_checks++; if (out_data1 !== '0) $display("FAIL midjob_reset_data1: got %0h required 0", out_data1); else n_pass++;
        n_checks++; if (out_half !== 1'b0) $display("FAIL midjob_reset_half: got %b required 0", out_half); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_start_conv = 1'b0;
        $display("test_lanes_gapped_reset: %0d outputs, %0d half", st_valid, st_half);
    endtask

    // Fresh job after the abort: Nci=8, Nco=8, all ones, every output 8.
    // in_start_conv and a changed config are applied during ACCUM.
    task automatic test_ones_full();
        run_stream(8, 3'd0, 8, 3'd0, 0, 0, 1'b1, -1, 0, 0, 0,
                   30'd8, 30'd8, 30'd8);
        n_checks++; if (st_bad !== 0) $display("FAIL ones_data: %0d bad cycles required 0, first %s", st_bad, st_first_bad); else n_pass++;
        n_checks++; if (st_valid !== 15128) $display("FAIL ones_valid_count: got %0d required 15128", st_valid); else n_pass++;
        n_checks++; if (st_half !== 488) $display("FAIL ones_half_count: got %0d required 488", st_half); else n_pass++;
        n_checks++; if (st_end !== 1) $display("FAIL ones_end_count: got %0d required 1", st_end); else n_pass++;
        n_checks++; if (st_end_cyc - st_last_valid_cyc !== 1) $display("FAIL ones_end_lag: got %0d required 1", st_end_cyc - st_last_valid_cyc); else n_pass++;
        $display("test_ones_full: %0d outputs, %0d half, %0d end pulses", st_valid, st_half, st_end);
    endtask

    initial begin
        test_reset();
        test_idle_valid();
        test_lanes_gapped_reset();
        test_ones_full();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 Parameter LEN_IN, default 25, is the width of one per-channel partial sum (signed two's complement).
REQ-002 Parameter LEN_OUT, default 30, is the accumulated output width: LEN_IN + 5 bits, exact for 32 channels.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_start_conv  input  1  starts a job; sampled only in IDLE.
REQ-006 in_cfg_ci  input  3  channel count: 0=8, 1=16, 2=24, 3=32, others=32; latched at start.
REQ-007 in_cfg_co  input  3  kernel count, same encoding as in_cfg_ci; latched at start.
REQ-008 in_valid  input  1  one partial-sum beat is present this cycle.
REQ-009 in_psum0, in_psum1  input  LEN_IN each  partial sums for output columns 2b and 2b+1 of the current row.
REQ-010 out_valid  output  1  output beat valid.
REQ-011 out_data0, out_data1  output  LEN_OUT each  channel-summed results.
REQ-012 out_half  output  1  with out_valid, only out_data0 is meaningful (last beat of a row).
REQ-013 out_end_conv  output  1  one-cycle pulse when the job completes.

Function
REQ-014 Geometry fixed: 64x64 map, 4x4 kernel, 61x61 output; each row is 31 beats, beat 30 carrying column 60 in in_psum0 only, in_psum1 ignored.
REQ-015 Stream order: beat (0..30) within row (0..60) within channel (0..Nci-1) within kernel (0..Nco-1); counters advance only on in_valid.
REQ-016 States IDLE, ACCUM, DONE; IDLE->ACCUM on in_start_conv; ACCUM->DONE on the accepted last beat of the last kernel; DONE->IDLE after one cycle.
REQ-017 Buffer holds 1891 entries (61x31) of two LEN_OUT words, addressed row*31+beat.
REQ-018 Channel 0: sign-extend both inputs and write them; no output.
REQ-019 Channels 1..Nci-2: write buffer word plus sign-extended input, per lane.
REQ-020 Channel Nci-1: buffer word plus input is driven on out_data0/1 with out_valid exactly one cycle after the accepting in_valid edge; no write needed.
REQ-021 out_half = 1 on output beats where beat index was 30; out_data1 then 0.
REQ-022 When out_valid is 0, out_data0/1 hold 0.
REQ-023 out_end_conv pulses in the DONE cycle, one cycle after the final out_valid.
REQ-024 Addition is exact; no saturation; no overflow possible for Nci<=32 with LEN_OUT=LEN_IN+5.
REQ-025 in_valid in IDLE or DONE is ignored; in_start_conv outside IDLE is ignored.
REQ-026 Kernel rollover (last beat of channel Nci-1) resets channel/row/beat to 0 and increments kernel; the next beat is channel 0 of the new kernel, with no idle cycle required.
REQ-027 Back-to-back in_valid every cycle is sustained with no stall; there is no backpressure.

Reset
REQ-028 rst asserted forces IDLE, all counters 0, out_valid 0, out_half 0, out_data0/1 0, out_end_conv 0, immediately and regardless of clk.
REQ-029 Reset mid-job abandons the job; buffer contents need not be cleared because channel 0 overwrites them.

Structure
REQ-030 Shared package holds row/beat/size constants (61, 31, 1891), the cfg decode function (code -> 8/16/24/32), and the state encoding.
REQ-031 One sub-module psum_buffer: 1891x(2*LEN_OUT) array, combinational read, synchronous write; counters and FSM stay in the top.

Verification
REQ-032 Nci=8, Nco=8, every in_psum=1 -> every output word 8, 1891 out_valid beats per kernel, 61 of them with out_half=1, out_end_conv once.
REQ-033 Nci=32, Nco=8, psums = -2^24 on all beats -> outputs -2^29 exactly, no wrap.
REQ-034 Nci=16, channel c sends value c on lane 0 and 100 on lane 1 -> out_data0=120, out_data1=1600, one cycle after the last-channel beat.
REQ-035 Gapped in_valid (random 50% duty) with Nci=8, Nco=16 -> same results and beat count as gapless run; out_end_conv one cycle after last output.
REQ-036 rst asserted at kernel 2 row 30 -> outputs 0 immediately; fresh start with 1s reproduces REQ-032 results.
REQ-037 in_start_conv pulsed during ACCUM and in_valid in IDLE -> no effect on counters or outputs.
